// File: rtl/bin_to_bcd_pkg.sv
// bin_to_bcd_pkg: shared constants and state encoding for the binary-to-BCD
// converter and the display controller that consumes its digits.
//   BCD_W       - bits per BCD digit
//   NUM_DIGITS  - digits presented to the display (units/tens/hundreds)
//   MAX_DISPLAY - largest displayable value; larger results saturate to it
//   state_t     - IDLE/SHIFT/DONE sequencing states
package bin_to_bcd_pkg;

    localparam int unsigned BCD_W       = 4;
    localparam int unsigned NUM_DIGITS  = 3;
    // One extra accumulator digit (thousands) exists only to detect overflow.
    localparam int unsigned ACC_DIGITS  = NUM_DIGITS + 1;
    localparam int unsigned ACC_W       = BCD_W * ACC_DIGITS;
    localparam int unsigned MAX_DISPLAY = 999;

    localparam logic [BCD_W-1:0] SAT_UNITS    = BCD_W'(MAX_DISPLAY % 10);
    localparam logic [BCD_W-1:0] SAT_TENS     = BCD_W'((MAX_DISPLAY / 10) % 10);
    localparam logic [BCD_W-1:0] SAT_HUNDREDS = BCD_W'((MAX_DISPLAY / 100) % 10);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_bcd_if.sv
// bin_to_bcd_if: request/result bundle of the binary-to-BCD converter.
//   start, bin          - conversion request and the value to convert
//   busy, done          - conversion in progress / one-cycle completion pulse
//   N1, N2, N3          - units, tens, hundreds digits (held between results)
//   ovf                 - last converted value exceeded MAX_DISPLAY
// master: the requester; slave: the converter.
interface bin_to_bcd_if
    import bin_to_bcd_pkg::*;
#(
    parameter int unsigned WIDTH = 10
) ();

    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic [BCD_W-1:0] N1;
    logic [BCD_W-1:0] N2;
    logic [BCD_W-1:0] N3;
    logic             ovf;

    modport master (
        output start, bin,
        input  busy, done, N1, N2, N3, ovf
    );

    modport slave (
        input  start, bin,
        output busy, done, N1, N2, N3, ovf
    );

endinterface

// File: rtl/bin_to_bcd_add3.sv
// bcd_add3: combinational double-dabble digit correction.
//   din  - one 4-bit BCD accumulator digit
//   dout - din + 3 when din >= 5, otherwise din unchanged
module bcd_add3
    import bin_to_bcd_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= BCD_W'(5)) begin
            dout = din + BCD_W'(3);
        end
    end

endmodule

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential shift-and-add-3 binary-to-BCD converter.
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset, aborts any conversion
//   bus   - slave side of bin_to_bcd_if (start/bin in; busy/done/N1..N3/ovf out)
// One conversion takes WIDTH SHIFT cycles plus one DONE cycle; results above
// MAX_DISPLAY saturate to it and set ovf.
module bin_to_bcd
    import bin_to_bcd_pkg::*;
#(
    parameter int unsigned WIDTH = 10
) (
    input  logic         clk,
    input  logic         reset,
    bin_to_bcd_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     sh;
    logic [ACC_W-1:0]     acc;
    logic [CNT_W-1:0]     cnt;
    logic [ACC_W-1:0]     corr;
    logic [ACC_W+WIDTH-1:0] cat_nxt;
    logic [ACC_W-1:0]     acc_nxt;
    logic [BCD_W-1:0]     n1_q;
    logic [BCD_W-1:0]     n2_q;
    logic [BCD_W-1:0]     n3_q;
    logic                 ovf_q;

    // Correct every digit before the shift, then shift {acc, sh} as one word.
    for (genvar g = 0; g < ACC_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (acc[g*BCD_W +: BCD_W]),
            .dout (corr[g*BCD_W +: BCD_W])
        );
    end

    assign cat_nxt = {corr, sh} << 1;
    assign acc_nxt = cat_nxt[ACC_W+WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The result registers load on the final shift edge (the one entering
    // DONE) so the new digits are visible in the same cycle as the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh    <= '0;
            acc   <= '0;
            cnt   <= '0;
            n1_q  <= '0;
            n2_q  <= '0;
            n3_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sh  <= bus.bin;
                        acc <= '0;
                        cnt <= CNT_W'(WIDTH);
                    end
                end
                SHIFT: begin
                    sh  <= cat_nxt[WIDTH-1:0];
                    acc <= acc_nxt;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (acc_nxt[ACC_W-1 -: BCD_W] != '0) begin
                            n1_q  <= SAT_UNITS;
                            n2_q  <= SAT_TENS;
                            n3_q  <= SAT_HUNDREDS;
                            ovf_q <= 1'b1;
                        end else begin
                            n1_q  <= acc_nxt[0*BCD_W +: BCD_W];
                            n2_q  <= acc_nxt[1*BCD_W +: BCD_W];
                            n3_q  <= acc_nxt[2*BCD_W +: BCD_W];
                            ovf_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
        bus.N1   = n1_q;
        bus.N2   = n2_q;
        bus.N3   = n3_q;
        bus.ovf  = ovf_q;
    end

endmodule

// File: doc/bin_to_bcd.md
Name: bin_to_bcd

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Produces the three BCD digits N1 (units), N2 (tens) and N3 (hundreds) that feed the 7-segment digit decoder and its leading-zero blanking.
- Converts one binary value per request, using a start/busy/done handshake.
- Results above 999 saturate to 999 and raise an overflow flag.

Parameters:
- WIDTH, 10, width of the binary input; legal range 1..10.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  WIDTH  unsigned value to convert; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress (state != IDLE).
- done  output  1  one-cycle pulse when N1..N3 and ovf are updated.
- N1  output  4  units digit (0..9).
- N2  output  4  tens digit (0..9).
- N3  output  4  hundreds digit (0..9).
- ovf  output  1  set when the last converted value exceeded 999; cleared by the next completion that is ≤ 999.

Behaviour:
- Reset values: state=IDLE; busy=0; done=0; N1=N2=N3=0; ovf=0; internal shift/BCD registers and counter = 0.
- Reset asserted mid-conversion aborts it: no done pulse, outputs return to 0.
- States and transitions:
  - IDLE: if start=1, load bin into the shift register, clear the 16-bit internal BCD accumulator (4 digits; thousands digit used only for overflow), set counter=WIDTH, go to SHIFT. If start=0, stay.
  - SHIFT: each cycle, add 3 to every accumulator digit ≥ 5, then shift {accumulator, shift register} left by 1 and decrement the counter. When the counter reaches 0 after the final shift, go to DONE. Exactly WIDTH cycles are spent in SHIFT.
  - DONE: register the outputs, pulse done=1 for this cycle, return to IDLE.
- Output rule in DONE:
  - If the thousands digit != 0: N3=N2=N1=9, ovf=1.
  - Otherwise: N1/N2/N3 take the units/tens/hundreds digits, ovf=0.
- Latency: start accepted at rising edge t0; busy=1 from t0 through the edge that leaves DONE. done=1 and the new digits are visible during cycle t0+WIDTH+1 (11 cycles for WIDTH=10).
- start while busy (SHIFT or DONE): ignored, not queued; bin changes during a conversion have no effect.
- Back-to-back operation: start high in the cycle after done (state IDLE) is accepted; maximum throughput is one conversion per WIDTH+2 cycles.
- Holding: N1..N3 and ovf hold their last values between completions and never show intermediate values.
- Width rules:
  - The add-3 correction is applied per 4-bit digit before the shift, never after.
  - No digit in the accumulator may exceed 9 at completion.

Decomposition:
- Shared package holds:
  - BCD_W=4 and NUM_DIGITS=3.
  - MAX_DISPLAY=999 saturation constant.
  - State encoding IDLE/SHIFT/DONE, also reused by the display controller.
- One natural sub-module, bcd_add3: a combinational 4-bit digit correction (in ≥ 5 → in+3, else in). It is instantiated once per accumulator digit (4 instances).

Test Plan:
- Zero: reset, then start with bin=0 → done exactly 11 cycles after the accepting edge; N3=0, N2=0, N1=0, ovf=0; busy high for 11 cycles.
- Mid-range: bin=255 → N3=2, N2=5, N1=5, ovf=0.
- Upper bound and saturation: bin=999 → N3=9, N2=9, N1=9, ovf=0. Then bin=1000 → 9,9,9, ovf=1. Then bin=1023 → 9,9,9, ovf=1. Then bin=7 → 0,0,7, ovf=0.
- Ignored start and input change: start bin=42, assert start again with bin=999 at cycle 4 of busy, and change bin during SHIFT → single done pulse, result 0,4,2; no second conversion starts.
- Reset mid-conversion: start bin=513, assert reset during cycle 5 of SHIFT → busy=0, done never pulses, N1..N3=0, ovf=0. After release, start bin=513 → 5,1,3.
- Back-to-back: start bin=128, then assert start with bin=64 in the cycle after done → second done 12 cycles after the first; outputs 1,2,8 then 0,6,4.
